ivector_rr_sched: RTL and testbench

- Output-side scheduler for the per-method FIFO bank of the indication vector.
- Watches the deq-ready of NUM_REQ FIFOs and grants exactly one FIFO per accepted beat, using round-robin.
- Pops the granted FIFO and registers {method index, payload} into a single output stage that drives the heard indication.
- Replaces OR-merging of FIFO outputs with a one-hot grant plus a backpressure-correct handshake.

---
 rtl/ivector_rr_sched_if.sv | 40 ++++
 rtl/ivector_rr_sched.sv | 151 +++++++++++++++
 tb/tb_ivector_rr_sched.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ivector_rr_sched_if.sv
// ----------------------------------------------------------------------------
// ivector_rr_sched_if
//   Bundles the FIFO-bank side and the heard-indication side of the
//   indication-vector output scheduler.
//
//   Handshakes:
//     req side  : req_deq_rdy[i] means FIFO i is non-empty and its head sits in
//                 req_first slice i.  req_deq_ena[i] pops FIFO i in that cycle.
//                 ENA is only ever raised on a bit whose RDY is high.
//     out side  : out_heard_ena is valid and out_heard_rdy is ready.  A beat
//                 transfers on a clock edge where both are high.  While valid is
//                 high and ready is low, meth and v are held stable.
//
//   Modports:
//     master : the scheduler
//     slave  : the environment (FIFO bank plus downstream consumer)
// ----------------------------------------------------------------------------
interface ivector_rr_sched_if #(
    parameter int NUM_REQ    = 10,
    parameter int DATA_WIDTH = 32,
    parameter int METH_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_deq_rdy;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_first;
    logic [NUM_REQ-1:0]            req_deq_ena;
    logic                          out_heard_ena;
    logic [METH_WIDTH-1:0]         out_heard_meth;
    logic [DATA_WIDTH-1:0]         out_heard_v;
    logic                          out_heard_rdy;

    modport master (
        input  req_deq_rdy, req_first, out_heard_rdy,
        output req_deq_ena, out_heard_ena, out_heard_meth, out_heard_v
    );

    modport slave (
        output req_deq_rdy, req_first, out_heard_rdy,
        input  req_deq_ena, out_heard_ena, out_heard_meth, out_heard_v
    );
endinterface

// File: rtl/ivector_rr_sched.sv
// ----------------------------------------------------------------------------
// ivector_rr_sched
//   Round-robin output scheduler for the per-method FIFO bank of the indication
//   vector.  One FIFO is granted per accepted beat; the granted head is popped
//   and registered together with its index into a single output stage.
//
//   Ports:
//     CLK          clock, all state on posedge
//     RST          synchronous active-high reset
//     bus          ivector_rr_sched_if.master (FIFO bank + heard output)
//     o_dbg_state  current output-stage state (0 = EMPTY, 1 = FULL)
//
//   Optional feature macro: IVECTOR_SCHED_BURST_EN
//     When defined, the last granted requester may be re-granted up to
//     MAX_BURST consecutive beats before round-robin moves on.
// ----------------------------------------------------------------------------
module ivector_rr_sched #(
    parameter int NUM_REQ    = 10,
    parameter int DATA_WIDTH = 32,
    parameter int METH_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    ivector_rr_sched_if.master    bus,
    output logic                  o_dbg_state
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                r_state;
    logic [METH_WIDTH-1:0] r_meth;
    logic [DATA_WIDTH-1:0] r_v;
    logic [PTR_W-1:0]      r_ptr;

    logic                  w_valid;
    logic                  w_xfer;
    logic                  w_load_ok;
    logic                  w_any;
    logic                  w_load;
    logic [PTR_W:0]        w_sum;
    logic                  w_rr_found;
    logic [PTR_W-1:0]      w_rr;
    logic [PTR_W-1:0]      w_grant;
    logic [PTR_W-1:0]      w_ptr_next;
    logic [NUM_REQ-1:0]    w_deq;
    logic [DATA_WIDTH-1:0] w_slot [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
        assign w_slot[gi] = bus.req_first[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_valid   = (r_state == ST_FULL);
    assign w_xfer    = w_valid & bus.out_heard_rdy;
    assign w_load_ok = ~w_valid | w_xfer;
    assign w_any     = |bus.req_deq_rdy;
    // Never pop during reset: the beat could not be registered.
    assign w_load    = w_load_ok & w_any & ~RST;

    // Rotating scan starting at r_ptr; the sum is one bit wider so the
    // wrap back below NUM_REQ is a single conditional subtract.
    always_comb begin
        w_sum      = '0;
        w_rr_found = 1'b0;
        w_rr       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
            end
            if (!w_rr_found && bus.req_deq_rdy[w_sum[PTR_W-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr       = w_sum[PTR_W-1:0];
            end
        end
    end

`ifdef IVECTOR_SCHED_BURST_EN
    localparam int BC_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    logic [BC_W-1:0]  r_burst_cnt;
    logic [PTR_W-1:0] w_last;
    logic             w_burst;

    // r_meth always holds a valid index (< NUM_REQ), so its low bits
    // address the requester granted by the previous load.
    assign w_last  = r_meth[PTR_W-1:0];
    assign w_burst = bus.req_deq_rdy[w_last] && (int'(r_burst_cnt) < MAX_BURST - 1);
    assign w_grant = w_burst ? w_last : w_rr;
`else
    assign w_grant = w_rr;
`endif

    assign w_ptr_next = (w_grant == PTR_W'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;

    always_comb begin
        w_deq = '0;
        if (w_load) begin
            w_deq[w_grant] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_EMPTY;
            r_meth  <= '0;
            r_v     <= '0;
            r_ptr   <= '0;
`ifdef IVECTOR_SCHED_BURST_EN
            r_burst_cnt <= '0;
`endif
        end else begin
            case (r_state)
                ST_EMPTY, ST_FULL: begin
                    if (w_load) begin
                        // Covers both fill-from-empty and replace-on-transfer.
                        r_state <= ST_FULL;
                        r_meth  <= METH_WIDTH'(w_grant);
                        r_v     <= w_slot[w_grant];
`ifdef IVECTOR_SCHED_BURST_EN
                        if (w_burst) begin
                            r_burst_cnt <= r_burst_cnt + 1'b1;
                        end else begin
                            r_burst_cnt <= '0;
                            r_ptr       <= w_ptr_next;
                        end
`else
                        r_ptr   <= w_ptr_next;
`endif
                    end else if (w_xfer) begin
                        r_state <= ST_EMPTY;
`ifdef IVECTOR_SCHED_BURST_EN
                        r_burst_cnt <= '0;
`endif
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    assign bus.req_deq_ena    = w_deq;
    assign bus.out_heard_ena  = w_valid;
    assign bus.out_heard_meth = r_meth;
    assign bus.out_heard_v    = r_v;
    assign o_dbg_state        = r_state;
endmodule

// File: tb/tb_ivector_rr_sched.sv
// ----------------------------------------------------------------------------
// tb_ivector_rr_sched
//   Bench for ivector_rr_sched.  The FIFO bank is modelled with queues; a
//   reference model tracks the output stage and round-robin pointer from the
//   scheduling rules, and a negedge compare process checks every cycle.
// ----------------------------------------------------------------------------
module tb_ivector_rr_sched;
    localparam int N  = 10;
    localparam int DW = 32;
    localparam int MW = 32;
    localparam int MB = 4;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic dbg_state;
    always #5 CLK = ~CLK;

    ivector_rr_sched_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .METH_WIDTH(MW)) bus ();

    ivector_rr_sched #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .METH_WIDTH(MW), .MAX_BURST(MB)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus),
        .o_dbg_state(dbg_state)
    );

    // ---------------- bench state ----------------
    logic [DW-1:0] fifo [N][$];
    logic [63:0]   exp_q [$];
    int            checks   = 0;
    int            failures = 0;
    bit            chk_en   = 1'b0;
    bit            rst_v    = 1'b1;
    bit            hrdy_v   = 1'b0;

    // reference model state
    bit            m_valid = 1'b0;
    int            m_meth  = 0;
    logic [DW-1:0] m_v     = '0;
    int            m_ptr   = 0;
    int            m_bcnt  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int rr_pick(input logic [N-1:0] rdy);
        for (int k = 0; k < N; k++) begin
            if (rdy[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic bit burst_hit(input logic [N-1:0] rdy);
`ifdef IVECTOR_SCHED_BURST_EN
        return (m_bcnt < MB - 1) && rdy[m_meth];
`else
        return 1'b0;
`endif
    endfunction

    function automatic int pick(input logic [N-1:0] rdy);
        return burst_hit(rdy) ? m_meth : rr_pick(rdy);
    endfunction

    // Advance the model by one clock edge using the inputs held at that edge.
    task automatic model_update();
        logic [N-1:0] rdy;
        bit xfer, brst;
        int g;
        rdy = bus.req_deq_rdy;
        if (RST) begin
            m_valid = 1'b0; m_meth = 0; m_v = '0; m_ptr = 0; m_bcnt = 0;
            exp_q.delete();
        end else begin
            xfer = m_valid && bus.out_heard_rdy;
            g    = pick(rdy);
            brst = burst_hit(rdy);
            if ((!m_valid || xfer) && g >= 0) begin
                if (brst) m_bcnt++;
                else begin
                    m_bcnt = 0;
                    m_ptr  = (g + 1) % N;
                end
                m_valid = 1'b1;
                m_meth  = g;
                m_v     = fifo[g].pop_front();
                exp_q.push_back({32'(g), m_v});
            end else if (xfer) begin
                m_valid = 1'b0;
                m_bcnt  = 0;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply();
        RST = rst_v;
        bus.out_heard_rdy = hrdy_v;
        for (int i = 0; i < N; i++) begin
            bus.req_deq_rdy[i]        = (fifo[i].size() != 0);
            bus.req_first[i*DW +: DW] = (fifo[i].size() != 0) ? fifo[i][0] : '0;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_update();
        #1;
        apply();
        #1;
    endtask

    task automatic clear_fifos();
        for (int i = 0; i < N; i++) fifo[i].delete();
    endtask

    task automatic do_reset();
        clear_fifos();
        rst_v = 1'b1;
        apply();
        tick();
        tick();
        rst_v = 1'b0;
        apply();
        #1;
    endtask

    // ---------------- compare process ----------------
    always @(negedge CLK) begin : cmp
        logic [N-1:0] exp_deq;
        int g;
        if (chk_en) begin
            exp_deq = '0;
            g = pick(bus.req_deq_rdy);
            if (!RST && (!m_valid || bus.out_heard_rdy) && g >= 0) exp_deq[g] = 1'b1;
            check("deq_ena", 64'(bus.req_deq_ena), 64'(exp_deq));
            check("heard_ena", 64'(bus.out_heard_ena), 64'(m_valid));
            check("dbg_state", 64'(dbg_state), 64'(m_valid));
            if (m_valid) begin
                check("heard_meth", 64'(bus.out_heard_meth), 64'(m_meth));
                check("heard_v", 64'(bus.out_heard_v), 64'(m_v));
            end
            // scoreboard: every accepted beat must be the next popped head
            if (bus.out_heard_ena && bus.out_heard_rdy) begin
                if (exp_q.size() == 0) check("sb_empty", 64'(1), 64'(0));
                else check("sb_beat", {bus.out_heard_meth, bus.out_heard_v}, exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    int seq6 [9];

    initial begin
        for (int i = 0; i < N; i++) fifo[i] = {};
        apply();
        tick();
        chk_en = 1'b1;

        // 1: reset and single beat
        tick();
        tick();
        check("t1_rst_ena", 64'(bus.out_heard_ena), 64'(0));
        check("t1_rst_deq", 64'(bus.req_deq_ena), 64'(0));
        rst_v  = 1'b0;
        hrdy_v = 1'b1;
        fifo[3].push_back(32'hDEAD_0003);
        apply();
        #1;
        check("t1_deq", 64'(bus.req_deq_ena), 64'(10'b0000001000));
        tick();
        check("t1_ena", 64'(bus.out_heard_ena), 64'(1));
        check("t1_meth", 64'(bus.out_heard_meth), 64'(3));
        check("t1_v", 64'(bus.out_heard_v), 64'(32'hDEAD_0003));
        tick();

`ifndef IVECTOR_SCHED_BURST_EN
        // 2: all ready, 12 beats at full throughput
        do_reset();
        hrdy_v = 1'b1;
        for (int i = 0; i < N; i++) begin
            fifo[i].push_back(32'hA000_0000 + 32'(i));
            fifo[i].push_back(32'hB000_0000 + 32'(i));
        end
        apply();
        #1;
        for (int b = 0; b < 12; b++) begin
            tick();
            check("t2_ena", 64'(bus.out_heard_ena), 64'(1));
            check("t2_meth", 64'(bus.out_heard_meth), 64'(b % N));
        end
        check("t2_v11", 64'(bus.out_heard_v), 64'(32'hB000_0001));
`endif

        // 3: backpressure
        do_reset();
        fifo[2].push_back(32'h0000_0022);
        fifo[5].push_back(32'h0000_0055);
        hrdy_v = 1'b0;
        apply();
        #1;
        check("t3_deq0", 64'(bus.req_deq_ena), 64'(10'b0000000100));
        tick();
        for (int c = 0; c < 4; c++) begin
            check("t3_hold_meth", 64'(bus.out_heard_meth), 64'(2));
            check("t3_hold_ena", 64'(bus.out_heard_ena), 64'(1));
            check("t3_hold_deq", 64'(bus.req_deq_ena), 64'(0));
            if (c < 3) tick();
        end
        hrdy_v = 1'b1;
        apply();
        #1;
        check("t3_deq5", 64'(bus.req_deq_ena), 64'(10'b0000100000));
        tick();
        check("t3_meth5", 64'(bus.out_heard_meth), 64'(5));
        check("t3_v5", 64'(bus.out_heard_v), 64'(32'h0000_0055));

`ifndef IVECTOR_SCHED_BURST_EN
        // 4: wrap-around
        do_reset();
        hrdy_v = 1'b1;
        fifo[8].push_back(32'h0000_0088);
        apply();
        tick();
        check("t4_meth8", 64'(bus.out_heard_meth), 64'(8));
        fifo[0].push_back(32'h0000_0100);
        apply();
        #1;
        check("t4_deq0", 64'(bus.req_deq_ena), 64'(10'b0000000001));
        tick();
        check("t4_meth0", 64'(bus.out_heard_meth), 64'(0));
        fifo[0].push_back(32'h0000_0200);
        fifo[1].push_back(32'h0000_0201);
        apply();
        #1;
        check("t4_ptr1", 64'(bus.req_deq_ena), 64'(10'b0000000010));
        tick();
        fifo[9].push_back(32'h0000_0299);
        apply();
        #1;
        check("t4_deq9", 64'(bus.req_deq_ena), 64'(10'b1000000000));
        tick();
        check("t4_meth9", 64'(bus.out_heard_meth), 64'(9));
        tick();
        check("t4_meth0b", 64'(bus.out_heard_meth), 64'(0));
        tick();
`endif

        // 5: reset mid-operation
        do_reset();
        hrdy_v = 1'b0;
        fifo[7].push_back(32'h0000_0077);
        apply();
        tick();
        check("t5_meth7", 64'(bus.out_heard_meth), 64'(7));
        fifo[7].push_back(32'h0000_0177);
        fifo[8].push_back(32'h0000_0188);
        rst_v = 1'b1;
        apply();
        #1;
        check("t5_rst_deq", 64'(bus.req_deq_ena), 64'(0));
        tick();
        check("t5_rst_ena", 64'(bus.out_heard_ena), 64'(0));
        check("t5_rst_deq2", 64'(bus.req_deq_ena), 64'(0));
        rst_v = 1'b0;
        apply();
        #1;
        check("t5_first_grant", 64'(bus.req_deq_ena), 64'(10'b0010000000));
        tick();
        check("t5_meth", 64'(bus.out_heard_meth), 64'(7));
        check("t5_v", 64'(bus.out_heard_v), 64'(32'h0000_0177));

        // 6: FIFOs 1 and 4 continuously ready
`ifdef IVECTOR_SCHED_BURST_EN
        seq6 = '{1, 1, 1, 1, 4, 4, 4, 4, 1};
`else
        seq6 = '{1, 4, 1, 4, 1, 4, 1, 4, 1};
`endif
        do_reset();
        hrdy_v = 1'b1;
        for (int j = 0; j < 12; j++) begin
            fifo[1].push_back(32'h0001_0000 + 32'(j));
            fifo[4].push_back(32'h0004_0000 + 32'(j));
        end
        apply();
        for (int b = 0; b < 9; b++) begin
            tick();
            check("t6_meth", 64'(bus.out_heard_meth), 64'(seq6[b]));
        end

        // randomized traffic with backpressure and occasional reset
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (fifo[i].size() < 4 && $urandom_range(0, 3) == 0) fifo[i].push_back($urandom);
            end
            hrdy_v = ($urandom_range(0, 3) != 0);
            rst_v  = ($urandom_range(0, 299) == 0);
            apply();
            tick();
        end

        // drain
        rst_v  = 1'b0;
        hrdy_v = 1'b1;
        apply();
        for (int c = 0; c < 60; c++) tick();
        check("drain_ena", 64'(bus.out_heard_ena), 64'(0));
        check("drain_sb", 64'(exp_q.size()), 64'(0));

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
